// File: rtl/neopixel_tx.sv
// neopixel_tx: serializes a frame of 24-bit GRB pixel words onto a WS2812 single-wire line,
// MSB first, followed by a low latch period. Words arrive over a valid/ready handshake.
module neopixel_tx #(
  parameter int unsigned NUM_PIXELS   = 4,
  parameter int unsigned BIT_CYCLES   = 63,
  parameter int unsigned T0H_CYCLES   = 18,
  parameter int unsigned T1H_CYCLES   = 35,
  parameter int unsigned LATCH_CYCLES = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        data_out,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_PIXELS + 1);
  localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND, ST_LATCH} state_t;

  state_t             state, state_next;
  logic [PIX_W-1:0]   shifter, shifter_next;
  logic [PIX_W-1:0]   buf_data, buf_data_next;
  logic               buf_full, buf_full_next;
  logic [CNT_W-1:0]   pix_accepted, accepted_next;
  logic [CNT_W-1:0]   pixels_sent, sent_next;
  logic [IDX_W-1:0]   bit_idx, bit_idx_next;
  logic [CYC_W-1:0]   cyc, cyc_next;
  logic [LAT_W-1:0]   latch_cnt, latch_cnt_next;
  logic               underrun_next, done_next, data_out_next;
  logic               load, transfer;
  logic [CYC_W-1:0]   high_time;

  assign busy      = (state != ST_IDLE);
  assign pix_ready = busy & ~buf_full & (pix_accepted < CNT_W'(NUM_PIXELS)) & (state != ST_LATCH);
  assign transfer  = pix_valid & pix_ready;
  assign high_time = shifter[PIX_W-1] ? CYC_W'(T1H_CYCLES) : CYC_W'(T0H_CYCLES);

  // Next-state, datapath and output decode
  always_comb begin
    state_next     = state;
    shifter_next   = shifter;
    buf_data_next  = buf_data;
    buf_full_next  = buf_full;
    accepted_next  = pix_accepted;
    sent_next      = pixels_sent;
    bit_idx_next   = bit_idx;
    cyc_next       = cyc;
    latch_cnt_next = latch_cnt;
    underrun_next  = underrun;
    done_next      = 1'b0;
    data_out_next  = 1'b0;
    load           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_WAIT;
          underrun_next = 1'b0;
          accepted_next = '0;
          sent_next     = '0;
          buf_full_next = 1'b0;
        end
      end
      ST_WAIT: begin
        if (buf_full) begin
          load       = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        data_out_next = (cyc < high_time);
        if (cyc == CYC_W'(BIT_CYCLES - 1)) begin
          cyc_next = '0;
          if (bit_idx == '0) begin
            if (pixels_sent == CNT_W'(NUM_PIXELS)) begin
              state_next     = ST_LATCH;
              latch_cnt_next = '0;
            end else if (buf_full) begin
              load = 1'b1;
            end else begin
              underrun_next = 1'b1;
              state_next    = ST_WAIT;
            end
          end else begin
            shifter_next = {shifter[PIX_W-2:0], 1'b0};
            bit_idx_next = bit_idx - IDX_W'(1);
          end
        end else begin
          cyc_next = cyc + CYC_W'(1);
        end
      end
      ST_LATCH: begin
        // One extra cycle covers the registered data_out lag so the line is low LATCH_CYCLES clocks
        if (latch_cnt == LAT_W'(LATCH_CYCLES)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          latch_cnt_next = latch_cnt + LAT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load) begin
      shifter_next  = buf_data;
      buf_full_next = 1'b0;
      cyc_next      = '0;
      bit_idx_next  = IDX_W'(PIX_W - 1);
      sent_next     = pixels_sent + CNT_W'(1);
    end

    if (transfer) begin
      buf_data_next = pix_data;
      buf_full_next = 1'b1;
      accepted_next = pix_accepted + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      shifter      <= '0;
      buf_data     <= '0;
      buf_full     <= 1'b0;
      pix_accepted <= '0;
      pixels_sent  <= '0;
      bit_idx      <= '0;
      cyc          <= '0;
      latch_cnt    <= '0;
      underrun     <= 1'b0;
      done         <= 1'b0;
      data_out     <= 1'b0;
    end else begin
      state        <= state_next;
      shifter      <= shifter_next;
      buf_data     <= buf_data_next;
      buf_full     <= buf_full_next;
      pix_accepted <= accepted_next;
      pixels_sent  <= sent_next;
      bit_idx      <= bit_idx_next;
      cyc          <= cyc_next;
      latch_cnt    <= latch_cnt_next;
      underrun     <= underrun_next;
      done         <= done_next;
      data_out     <= data_out_next;
    end
  end

endmodule

// File: tb/tb_neopixel_tx.sv
// tb_neopixel_tx: directed frames; a monitor decodes the WS2812 bitstream and checks each
// pixel against a queue of words pushed when the stimulus sees them accepted.
module tb_neopixel_tx;

  localparam int unsigned BC  = 63;
  localparam int unsigned T0  = 18;
  localparam int unsigned T1  = 35;
  localparam int unsigned LAT = 2500;
  localparam int unsigned NP  = 4;
  localparam int unsigned FRAME_CYC = 2 + NP * 24 * BC + LAT;
  localparam int unsigned MID = (T0 + T1) / 2;

  logic        clock = 1'b0;
  logic        reset, start, pix_valid, pix_ready, data_out, busy, done, underrun;
  logic [23:0] pix_data;

  int unsigned cyc_n = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [23:0] exp_q[$];
  logic        mon_reset = 1'b0;
  logic        chk_period = 1'b1;

  logic        mon_prev = 1'b0;
  int unsigned mon_hi = 0;
  int unsigned mon_nb = 0;
  logic [23:0] mon_acc = '0;
  int unsigned mon_last = 0;
  logic        mon_have = 1'b0;

  logic [23:0] f3_words [4];
  int unsigned f3_gaps  [4];

  neopixel_tx #(
    .NUM_PIXELS(NP), .BIT_CYCLES(BC), .T0H_CYCLES(T0), .T1H_CYCLES(T1), .LATCH_CYCLES(LAT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .data_out(data_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Offer a word until accepted; returns the edge index of the transfer, valid left high
  task automatic send_word(input logic [23:0] w, output int unsigned acc);
    pix_valid = 1'b1;
    pix_data  = w;
    acc       = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pix_ready) begin
        exp_q.push_back(w);
        acc = cyc_n + 1;
        tick();
        return;
      end
      tick();
    end
    check("ready_timeout", 32'(pix_ready), 32'd1);
  endtask

  task automatic wait_done(input int unsigned exp_cyc, input logic probe, output int unsigned dcyc);
    dcyc = 0;
    for (int i = 0; i < 12000; i++) begin
      if (done) begin
        dcyc = cyc_n;
        break;
      end
      if (i == 5) begin
        check("extra_not_ready", 32'(pix_ready), 32'd0);
        check("busy_in_frame", 32'(busy), 32'd1);
      end
      if (probe && i == 10) start = 1'b1;
      if (probe && i == 11) begin
        start = 1'b0;
        check("start_ignored_ready", 32'(pix_ready), 32'd0);
        check("start_ignored_underrun", 32'(underrun), 32'd0);
      end
      tick();
    end
    check("done_cycle", dcyc, exp_cyc);
  endtask

  // Bitstream decoder
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_reset) begin
        mon_prev = 1'b0;
        mon_hi   = 0;
        mon_nb   = 0;
        mon_acc  = '0;
        mon_have = 1'b0;
      end else begin
        if (data_out) begin
          if (!mon_prev) begin
            if (mon_have && chk_period) check("bit_period", cyc_n - mon_last, BC);
            mon_last = cyc_n;
            mon_have = 1'b1;
            mon_hi   = 0;
          end
          mon_hi++;
        end else if (mon_prev) begin
          check("pulse_width", mon_hi, (mon_hi > MID) ? T1 : T0);
          mon_acc = {mon_acc[22:0], (mon_hi > MID) ? 1'b1 : 1'b0};
          mon_nb++;
          if (mon_nb == 24) begin
            mon_nb = 0;
            if (exp_q.size() == 0) check("extra_pixel", 32'(exp_q.size()), 32'd1);
            else check("pixel_word", 32'(mon_acc), 32'(exp_q.pop_front()));
          end
        end
        mon_prev = data_out;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation ran past its cycle limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned k0, k1, k2, g, d, tmp;
    logic any_high;
    f3_words = '{24'h123456, 24'h000000, 24'hFFFFFF, 24'h96E1A7};
    f3_gaps  = '{0, 137, 250, 31};
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    pix_valid = 1'b1; pix_data = 24'h777777;
    repeat (3) tick();
    check("idle_not_ready", 32'(pix_ready), 32'd0);
    pix_valid = 1'b0;

    // Frame 1: back-to-back words, first word 800000 for bit timing
    start = 1'b1; tick(); start = 1'b0;
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_ready", 32'(pix_ready), 32'd1);
    send_word(24'h800000, k0);
    check("f1_low_at_accept", 32'(data_out), 32'd0);
    send_word(24'hA53C0F, tmp);
    check("f1_w1_accept_cycle", tmp, k0 + 2);
    check("f1_first_rise", 32'(data_out), 32'd1);
    send_word(24'h000001, tmp);
    send_word(24'h5AFFC3, tmp);
    pix_data = 24'hBADBAD;
    wait_done(k0 + FRAME_CYC, 1'b1, d);
    check("f1_all_sent", 32'(exp_q.size()), 32'd0);
    check("f1_no_underrun", 32'(underrun), 32'd0);

    // Frame 2: start coincident with done, then underrun, then reset mid-bit
    pix_valid = 1'b0; start = 1'b1; chk_period = 1'b0;
    tick(); start = 1'b0;
    check("restart_done_cleared", 32'(done), 32'd0);
    check("restart_ready", 32'(pix_ready), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    send_word(24'h0F0F0F, k1);
    pix_valid = 1'b0;
    while (cyc_n < k1 + 24 * BC) tick();
    check("underrun_before", 32'(underrun), 32'd0);
    tick();
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_busy", 32'(busy), 32'd1);
    check("underrun_ready", 32'(pix_ready), 32'd1);
    any_high = 1'b0;
    repeat (200) begin
      tick();
      if (data_out) any_high = 1'b1;
    end
    check("underrun_line_low", 32'(any_high), 32'd0);
    check("f2_pix1_decoded", 32'(exp_q.size()), 32'd0);
    send_word(24'hC30081, g);
    pix_valid = 1'b0;
    check("resume_low_k", 32'(data_out), 32'd0);
    tick();
    check("resume_low_k1", 32'(data_out), 32'd0);
    tick();
    check("resume_high_k2", 32'(data_out), 32'd1);
    check("underrun_sticky", 32'(underrun), 32'd1);
    mon_reset = 1'b1; reset = 1'b1;
    tick();
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(pix_ready), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    mon_reset = 1'b0;
    repeat (5) tick();
    check("midrst_no_done", 32'(done), 32'd0);

    // Frame 3: valid gaps between words, extra word offered after the fourth
    chk_period = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    k2 = 0;
    for (int i = 0; i < 4; i++) begin
      if (f3_gaps[i] > 0) begin
        pix_valid = 1'b0;
        repeat (f3_gaps[i]) tick();
      end
      send_word(f3_words[i], tmp);
      if (i == 0) k2 = tmp;
    end
    pix_data = 24'hBADBAD;
    wait_done(k2 + FRAME_CYC, 1'b0, d);
    pix_valid = 1'b0;
    check("f3_all_sent", 32'(exp_q.size()), 32'd0);
    check("f3_no_underrun", 32'(underrun), 32'd0);
    tick();
    check("f3_done_one_cycle", 32'(done), 32'd0);
    check("f3_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
